fetch_unit: RTL and testbench

Instruction-fetch stage of the 8-bit pipelined processor, directly upstream of the decode/control stage. Owns the PC and the reset and interrupt vector sequencing. Assembles two-byte L-format instructions (opcode[7:4]=4'hC: LDM/LDD/STD) into opcode plus immediate. Presents one instruction per valid cycle to the IF/ID boundary, and raises int_req to drive the control unit's interrupt input.

---
 rtl/fetch_unit_if.sv | 49 ++++
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, decode-side control inputs and the IF/ID outputs.
// master = fetch_unit, slave = memory / decode environment.
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              interrupt;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [DATA_W-1:0] if_imm;
  logic [ADDR_W-1:0] if_pc_plus1;
  logic              int_req;
  logic [15:0]       perf_stall_cnt;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  redirect,
    input  redirect_pc,
    input  interrupt,
    output if_valid,
    output if_instr,
    output if_imm,
    output if_pc_plus1,
    output int_req,
    output perf_stall_cnt
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output redirect,
    output redirect_pc,
    output interrupt,
    input  if_valid,
    input  if_instr,
    input  if_imm,
    input  if_pc_plus1,
    input  int_req,
    input  perf_stall_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, reset/interrupt vectoring and two-byte L-format assembly.
// Optional macro FETCH_PERF_EN enables the saturating stall-cycle counter.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {S_VEC_RST, S_RUN, S_IMM, S_VEC_INT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] op_reg, op_next;
  logic              int_pend_reg, int_pend_next;
  logic              if_valid_reg, if_valid_next;
  logic [DATA_W-1:0] if_instr_reg, if_instr_next;
  logic [DATA_W-1:0] if_imm_reg, if_imm_next;
  logic [ADDR_W-1:0] if_pc_plus1_reg, if_pc_plus1_next;
  logic              int_req_reg, int_req_next;

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] rdata_as_pc;
  logic              is_lfmt;

  assign pc_plus1    = pc_reg + ADDR_W'(1);
  assign rdata_as_pc = ADDR_W'(bus.imem_rdata);
  assign is_lfmt     = (bus.imem_rdata[DATA_W-1 -: 4] == 4'hC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_VEC_RST;
      pc_reg          <= '0;
      op_reg          <= '0;
      int_pend_reg    <= 1'b0;
      if_valid_reg    <= 1'b0;
      if_instr_reg    <= '0;
      if_imm_reg      <= '0;
      if_pc_plus1_reg <= '0;
      int_req_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      op_reg          <= op_next;
      int_pend_reg    <= int_pend_next;
      if_valid_reg    <= if_valid_next;
      if_instr_reg    <= if_instr_next;
      if_imm_reg      <= if_imm_next;
      if_pc_plus1_reg <= if_pc_plus1_next;
      int_req_reg     <= int_req_next;
    end
  end

  // Interrupts are only taken from S_RUN so an opcode never loses its immediate.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_VEC_RST: state_next = S_RUN;
      S_RUN: begin
        if (!bus.redirect && !bus.stall) begin
          if (int_pend_reg)  state_next = S_VEC_INT;
          else if (is_lfmt)  state_next = S_IMM;
        end
      end
      S_IMM:     if (bus.redirect || !bus.stall) state_next = S_RUN;
      S_VEC_INT: state_next = S_RUN;
      default:   state_next = S_VEC_RST;
    endcase
  end

  always_comb begin
    pc_next          = pc_reg;
    op_next          = op_reg;
    int_pend_next    = int_pend_reg;
    if_valid_next    = if_valid_reg;
    if_instr_next    = if_instr_reg;
    if_imm_next      = if_imm_reg;
    if_pc_plus1_next = if_pc_plus1_reg;
    int_req_next     = int_req_reg;

    // Requests arriving while vectoring are dropped (no nesting).
    if (bus.interrupt && !int_pend_reg && state_reg != S_VEC_INT)
      int_pend_next = 1'b1;

    case (state_reg)
      S_VEC_RST: begin
        pc_next       = rdata_as_pc;
        if_valid_next = 1'b0;
      end
      S_RUN: begin
        if (bus.redirect) begin
          pc_next       = bus.redirect_pc;
          if_valid_next = 1'b0;
        end else if (!bus.stall) begin
          int_req_next = 1'b0;
          if (int_pend_reg) begin
            int_req_next     = 1'b1;
            if_valid_next    = 1'b0;
            if_instr_next    = '0;
            if_imm_next      = '0;
            if_pc_plus1_next = pc_reg;
            int_pend_next    = 1'b0;
          end else if (is_lfmt) begin
            op_next       = bus.imem_rdata;
            pc_next       = pc_plus1;
            if_valid_next = 1'b0;
          end else begin
            if_instr_next    = bus.imem_rdata;
            if_imm_next      = '0;
            if_pc_plus1_next = pc_plus1;
            if_valid_next    = 1'b1;
            pc_next          = pc_plus1;
          end
        end
      end
      S_IMM: begin
        if (bus.redirect) begin
          pc_next       = bus.redirect_pc;
          if_valid_next = 1'b0;
        end else if (!bus.stall) begin
          if_instr_next    = op_reg;
          if_imm_next      = bus.imem_rdata;
          if_pc_plus1_next = pc_plus1;
          if_valid_next    = 1'b1;
          pc_next          = pc_plus1;
        end
      end
      S_VEC_INT: begin
        pc_next       = rdata_as_pc;
        int_req_next  = 1'b0;
        if_valid_next = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_reg)
      S_VEC_RST: bus.imem_addr = '0;
      S_VEC_INT: bus.imem_addr = ADDR_W'(1);
      default:   bus.imem_addr = pc_reg;
    endcase
  end

  assign bus.if_valid    = if_valid_reg;
  assign bus.if_instr    = if_instr_reg;
  assign bus.if_imm      = if_imm_reg;
  assign bus.if_pc_plus1 = if_pc_plus1_reg;
  assign bus.int_req     = int_req_reg;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_cnt_reg <= '0;
    else if (bus.stall && (state_reg == S_RUN || state_reg == S_IMM) && perf_cnt_reg != 16'hFFFF)
      perf_cnt_reg <= perf_cnt_reg + 16'd1;
  end

  assign bus.perf_stall_cnt = perf_cnt_reg;
`else
  assign bus.perf_stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an instruction-level reference model predicts issued
// instructions, interrupt bubbles and stall holds; a monitor compares them against the DUT.
module tb_fetch_unit;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem [256];
  assign bus.imem_rdata = mem[bus.imem_addr];

  typedef struct packed {
    logic       is_int;
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc1;
  } ev_t;

  ev_t exp_q[$];
  bit  hold_q[$];
  int  checks   = 0;
  int  failures = 0;

  // Reference model: architectural PC plus "half-fetched opcode" and vectoring flags.
  logic [7:0] m_pc;
  logic [7:0] m_op;
  bit         m_have, m_pend, m_boot, m_vec;
  int         m_perf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_ins(input logic [7:0] ins, input logic [7:0] imm, input logic [7:0] pc1);
    ev_t e;
    e.is_int = 1'b0; e.instr = ins; e.imm = imm; e.pc1 = pc1;
    exp_q.push_back(e);
  endtask

  // Effect of one clock edge given the inputs presented for it.
  task automatic model_step(input bit st, input bit rd, input logic [7:0] rpc, input bit irq);
    bit hold = 1'b0;
    bit cap  = irq && !m_pend && !m_vec;
    ev_t e;
    if (m_boot) begin
      m_pc = mem[0]; m_boot = 1'b0;
    end else if (m_vec) begin
      m_pc = mem[1]; m_vec = 1'b0;
    end else begin
      if (st && m_perf < 65535) m_perf++;
      if (rd) begin
        m_pc = rpc; m_have = 1'b0;
      end else if (st) begin
        hold = 1'b1;
      end else if (m_have) begin
        push_ins(m_op, mem[m_pc], 8'(m_pc + 1));
        m_pc = 8'(m_pc + 1); m_have = 1'b0;
      end else if (m_pend) begin
        e.is_int = 1'b1; e.instr = 8'h00; e.imm = 8'h00; e.pc1 = m_pc;
        exp_q.push_back(e);
        m_pend = 1'b0; m_vec = 1'b1;
      end else if (mem[m_pc][7:4] == 4'hC) begin
        m_op = mem[m_pc]; m_have = 1'b1; m_pc = 8'(m_pc + 1);
      end else begin
        push_ins(mem[m_pc], 8'h00, 8'(m_pc + 1));
        m_pc = 8'(m_pc + 1);
      end
    end
    if (cap) m_pend = 1'b1;
    hold_q.push_back(hold);
  endtask

  task automatic drive(input bit st, input bit rd, input logic [7:0] rpc, input bit irq);
    bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc; bus.interrupt = irq;
    model_step(st, rd, rpc, irq);
    @(negedge clk);
  endtask

  // Monitor: one hold/no-hold verdict per edge, events popped when the DUT presents one.
  initial begin
    logic       p_valid, p_req;
    logic [7:0] p_instr, p_imm, p_pc1;
    bit         hold;
    ev_t        e;
    p_valid = 0; p_req = 0; p_instr = 0; p_imm = 0; p_pc1 = 0;
    forever begin
      @(posedge clk);
      #2;
      if (hold_q.size() > 0) begin
        hold = hold_q.pop_front();
        if (hold) begin
          check("stall_hold_valid", bus.if_valid, p_valid);
          check("stall_hold_instr", bus.if_instr, p_instr);
          check("stall_hold_imm", bus.if_imm, p_imm);
          check("stall_hold_pc1", bus.if_pc_plus1, p_pc1);
        end else if (bus.int_req || bus.if_valid) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output actual=valid:%0b int_req:%0b instr:%0h required=none",
                     bus.if_valid, bus.int_req, bus.if_instr);
          end else begin
            e = exp_q.pop_front();
            check("kind_int_req", bus.int_req, e.is_int);
            check("if_valid", bus.if_valid, !e.is_int);
            check("if_pc_plus1", bus.if_pc_plus1, e.pc1);
            if (!e.is_int) begin
              check("if_instr", bus.if_instr, e.instr);
              check("if_imm", bus.if_imm, e.imm);
            end
          end
        end
      end
      p_valid = bus.if_valid; p_req = bus.int_req;
      p_instr = bus.if_instr; p_imm = bus.if_imm; p_pc1 = bus.if_pc_plus1;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h80;
    mem[8'h10] = 8'hC5; mem[8'h11] = 8'h3A; mem[8'h12] = 8'h24; mem[8'h13] = 8'h31;
    mem[8'h14] = 8'hC7; mem[8'h15] = 8'h3B;
    mem[8'h40] = 8'h55; mem[8'h41] = 8'h56; mem[8'h42] = 8'h57;
    mem[8'h80] = 8'hC9; mem[8'h81] = 8'h11; mem[8'h82] = 8'h22; mem[8'hFF] = 8'h2E;
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0; bus.interrupt = 0;
    m_pc = 0; m_op = 0; m_have = 0; m_pend = 0; m_boot = 1; m_vec = 0; m_perf = 0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_if_valid", bus.if_valid, 1'b0);
    check("reset_if_instr", bus.if_instr, 8'h00);
    check("reset_if_imm", bus.if_imm, 8'h00);
    check("reset_if_pc_plus1", bus.if_pc_plus1, 8'h00);
    check("reset_int_req", bus.int_req, 1'b0);
    check("reset_imem_addr", bus.imem_addr, 8'h00);
    check("reset_perf", bus.perf_stall_cnt, 16'h0000);
    rst_n = 1'b1;

    // Directed: reset vector, L-format, 3-cycle stall, redirect during immediate,
    // interrupt in S_RUN, interrupt deferred past an L-format immediate.
    drive(0, 0, 8'h00, 0);              // vector M[0] -> pc 10
    drive(0, 0, 8'h00, 0);              // opcode C5
    drive(0, 0, 8'h00, 0);              // C5/3A, pc1 12
    drive(0, 0, 8'h00, 0);              // 24
    repeat (3) drive(1, 0, 8'h00, 0);   // stall x3
    drive(0, 0, 8'h00, 0);              // 31
    drive(0, 0, 8'h00, 0);              // opcode C7
    drive(0, 1, 8'h40, 0);              // redirect in S_IMM
    drive(0, 0, 8'h00, 0);              // 55
    drive(0, 0, 8'h00, 1);              // 56, interrupt captured
    drive(0, 0, 8'h00, 0);              // int_req, pc1 42
    drive(0, 0, 8'h00, 0);              // vector M[1]
    drive(0, 0, 8'h00, 1);              // opcode C9, interrupt captured
    drive(0, 0, 8'h00, 0);              // C9/11, pc1 82
    drive(0, 0, 8'h00, 0);              // int_req, pc1 82
    drive(0, 0, 8'h00, 0);              // vector
    drive(0, 1, 8'hFF, 0);              // redirect to top of memory for wrap

    for (int c = 0; c < 3000; c++) begin
      bit         st, rd, irq;
      logic [7:0] rpc;
      st  = ($urandom_range(0, 99) < 15);
      rd  = ($urandom_range(0, 99) < 6);
      irq = ($urandom_range(0, 99) < 4);
      rpc = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      drive(st, rd, rpc, irq);
    end
    repeat (6) drive(0, 0, 8'h00, 0);
    @(posedge clk);
    #4;
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef FETCH_PERF_EN
    check("perf_stall_cnt", bus.perf_stall_cnt, 16'(m_perf));
`else
    check("perf_stall_cnt_tied", bus.perf_stall_cnt, 16'h0000);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
